i2c_slave_deserializer: RTL and testbench

I2C_SLAVE_DESERIALIZER -- requirements
Module: i2c_slave_deserializer

---
 rtl/i2c_slave_deserializer_if.sv | 22 ++
 rtl/i2c_slave_deserializer.sv | 209 ++++++++++++++++++++
 tb/tb_i2c_slave_deserializer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_deserializer_if.sv
// Bus bundle between the I2C pins, the deserializer and the serializer/register side.
interface i2c_slave_deserializer_if;
  logic       i2c_scl;
  logic       i2c_sda;
  logic       i2c_ack;
  logic       i2c_xfc_read;
  logic       i2c_xfc_write;
  logic [7:0] i2c_wdata;
  logic [7:0] i2c_reg_addr;
  logic       stop_out;
  logic       busy;

  modport slave (
    input  i2c_scl, i2c_sda,
    output i2c_ack, i2c_xfc_read, i2c_xfc_write, i2c_wdata, i2c_reg_addr, stop_out, busy
  );

  modport master (
    output i2c_scl, i2c_sda,
    input  i2c_ack, i2c_xfc_read, i2c_xfc_write, i2c_wdata, i2c_reg_addr, stop_out, busy
  );
endinterface

// File: rtl/i2c_slave_deserializer.sv
// I2C slave receive side: pin synchronisation, START/STOP detection, address match,
// register pointer handling and write/read transfer strobes.
module i2c_slave_deserializer #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input logic                     Clock,
  input logic                     reset,
  i2c_slave_deserializer_if.slave bus
);

  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] LastBit = CntW'(8);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
  } state_e;

  logic scl_meta_q, scl_sync_q, scl_hist_q;
  logic sda_meta_q, sda_sync_q, sda_hist_q;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            rw_q, rw_d;
  logic            ack_q, ack_d;
  logic            xfc_read_q, xfc_read_d;
  logic            xfc_write_q, xfc_write_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      reg_addr_q, reg_addr_d;
  logic            stop_q, stop_d;
  logic            busy_q, busy_d;

  logic       scl_rise_c, scl_fall_c, start_c, stop_c;
  logic [7:0] shifted_c;

  assign scl_rise_c = scl_sync_q & ~scl_hist_q;
  assign scl_fall_c = ~scl_sync_q & scl_hist_q;
  // SCL must be high in both cycles, so a simultaneous SDA/SCL change never qualifies
  assign start_c    = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
  assign stop_c     = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;
  assign shifted_c  = {shift_q[6:0], sda_sync_q};

  // Two-flop synchronisers plus one history flop per line; idle bus level is high
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_hist_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_meta_q <= bus.i2c_scl;
      scl_sync_q <= scl_meta_q;
      scl_hist_q <= scl_sync_q;
      sda_meta_q <= bus.i2c_sda;
      sda_sync_q <= sda_meta_q;
      sda_hist_q <= sda_sync_q;
    end
  end

  // FSM state, bit counter, shifter and registered outputs
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      ack_q       <= 1'b0;
      xfc_read_q  <= 1'b0;
      xfc_write_q <= 1'b0;
      wdata_q     <= '0;
      reg_addr_q  <= '0;
      stop_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      ack_q       <= ack_d;
      xfc_read_q  <= xfc_read_d;
      xfc_write_q <= xfc_write_d;
      wdata_q     <= wdata_d;
      reg_addr_q  <= reg_addr_d;
      stop_q      <= stop_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and output decode; bus conditions override every state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    ack_d       = ack_q;
    xfc_read_d  = 1'b0;
    xfc_write_d = 1'b0;
    wdata_d     = wdata_q;
    reg_addr_d  = reg_addr_q;
    stop_d      = 1'b0;
    busy_d      = busy_q;

    if (start_c) begin
      stop_d  = busy_q;
      state_d = ADDR;
      cnt_d   = '0;
      ack_d   = 1'b0;
      busy_d  = 1'b0;
    end else if (stop_c) begin
      stop_d  = busy_q;
      state_d = IDLE;
      cnt_d   = '0;
      ack_d   = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR, REG, WDATA, RDATA: begin
          if (scl_rise_c && (cnt_q != LastBit)) begin
            shift_d = shifted_c;
            cnt_d   = cnt_q + CntW'(1);
            if ((state_q == WDATA) && (cnt_q == LastBit - CntW'(1))) begin
              wdata_d     = shifted_c;
              xfc_write_d = 1'b1;
            end
          end else if (scl_fall_c && (cnt_q == LastBit)) begin
            cnt_d = '0;
            if (state_q == ADDR) begin
              if (shift_q[7:1] == SLAVE_ADDR) begin
                state_d = ADDR_ACK;
                ack_d   = 1'b1;
                busy_d  = 1'b1;
                rw_d    = shift_q[0];
              end else begin
                state_d = IGNORE;
              end
            end else if (state_q == REG) begin
              reg_addr_d = shift_q;
              ack_d      = 1'b1;
              state_d    = REG_ACK;
            end else if (state_q == WDATA) begin
              ack_d   = 1'b1;
              state_d = WDATA_ACK;
            end else begin
              state_d = RACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall_c) begin
            ack_d = 1'b0;
            if (rw_q) begin
              xfc_read_d = 1'b1;
              state_d    = RDATA;
            end else begin
              state_d = REG;
            end
          end
        end
        REG_ACK: begin
          if (scl_fall_c) begin
            ack_d   = 1'b0;
            state_d = WDATA;
          end
        end
        WDATA_ACK: begin
          if (scl_fall_c) begin
            ack_d      = 1'b0;
            reg_addr_d = reg_addr_q + 8'd1;
            state_d    = WDATA;
          end
        end
        // cnt_q marks that the master-ACK rising edge has been seen
        RACK: begin
          if (scl_rise_c) begin
            if (!sda_sync_q) begin
              reg_addr_d = reg_addr_q + 8'd1;
              cnt_d      = CntW'(1);
            end else begin
              stop_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IGNORE;
            end
          end else if (scl_fall_c && (cnt_q == CntW'(1))) begin
            xfc_read_d = 1'b1;
            cnt_d      = '0;
            state_d    = RDATA;
          end
        end
        IDLE, IGNORE: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.i2c_ack       = ack_q;
  assign bus.i2c_xfc_read  = xfc_read_q;
  assign bus.i2c_xfc_write = xfc_write_q;
  assign bus.i2c_wdata     = wdata_q;
  assign bus.i2c_reg_addr  = reg_addr_q;
  assign bus.stop_out      = stop_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_i2c_slave_deserializer.sv
// Scoreboard bench for i2c_slave_deserializer: a bit-banged I2C master drives the pins,
// a transaction-level model predicts write/read strobes and stop pulses.
module tb_i2c_slave_deserializer;

  localparam int unsigned Q  = 4;       // Clock cycles per quarter SCL period
  localparam logic [6:0]  SA = 7'h50;

  logic Clock = 1'b0;
  logic reset;

  always #5 Clock = ~Clock;

  i2c_slave_deserializer_if bus ();

  i2c_slave_deserializer #(.SLAVE_ADDR(SA)) dut (
    .Clock (Clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] exp_wr[$];   // {reg_addr, wdata} per expected write strobe
  logic [7:0]  exp_rd[$];   // reg_addr per expected read strobe
  logic [7:0]  exp_stop[$]; // reg_addr seen with each expected stop_out pulse
  logic [7:0]  m_reg = 8'h00;

  function automatic void check(input string nm, input int act, input int want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, want, $time);
    end
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a strobe
  logic prev_rd = 1'b0, prev_wr = 1'b0, prev_st = 1'b0;
  always @(negedge Clock) begin
    if (bus.i2c_xfc_read && bus.i2c_xfc_write) check("xfc_exclusive", 1, 0);
    if (bus.i2c_xfc_read) begin
      check("xfc_read_width", int'(prev_rd), 0);
      if (exp_rd.size() == 0) check("xfc_read_unexpected", 1, 0);
      else check("xfc_read_addr", bus.i2c_reg_addr, exp_rd.pop_front());
    end
    if (bus.i2c_xfc_write) begin
      check("xfc_write_width", int'(prev_wr), 0);
      if (exp_wr.size() == 0) check("xfc_write_unexpected", 1, 0);
      else check("xfc_write_addr_data", {bus.i2c_reg_addr, bus.i2c_wdata}, exp_wr.pop_front());
    end
    if (bus.stop_out) begin
      check("stop_out_width", int'(prev_st), 0);
      if (exp_stop.size() == 0) check("stop_out_unexpected", 1, 0);
      else check("stop_out_reg_addr", bus.i2c_reg_addr, exp_stop.pop_front());
    end
    prev_rd = bus.i2c_xfc_read;
    prev_wr = bus.i2c_xfc_write;
    prev_st = bus.stop_out;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic quarter();
    repeat (Q) @(posedge Clock);
    #2;
  endtask

  // One SCL period with SDA set while SCL is low; ack checked mid-high
  task automatic clk_bit(input logic b, input logic want_ack, input string nm);
    bus.i2c_sda = b;
    quarter();
    bus.i2c_scl = 1'b1;
    quarter();
    check(nm, bus.i2c_ack, want_ack);
    quarter();
    bus.i2c_scl = 1'b0;
    quarter();
  endtask

  task automatic i2c_start();
    bus.i2c_sda = 1'b1;
    quarter();
    bus.i2c_scl = 1'b1;
    quarter();
    bus.i2c_sda = 1'b0;
    quarter();
    bus.i2c_scl = 1'b0;
    quarter();
  endtask

  task automatic i2c_stop();
    bus.i2c_sda = 1'b0;
    quarter();
    bus.i2c_scl = 1'b1;
    quarter();
    bus.i2c_sda = 1'b1;
    quarter();
    quarter();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic want_ack, input string nm);
    for (int i = 7; i >= 0; i--) clk_bit(b[i], 1'b0, "ack_low_on_data");
    clk_bit(1'b1, want_ack, nm);
  endtask

  task automatic read_byte(input logic nack);
    for (int i = 0; i < 8; i++) clk_bit(1'($urandom_range(0, 1)), 1'b0, "ack_low_on_rdata");
    clk_bit(nack, 1'b0, "ack_low_on_master_ack");
  endtask

  task automatic do_write(input logic [6:0] a7, input logic [7:0] r, input logic [7:0] data[$]);
    logic       hit;
    logic [7:0] ptr;
    hit = (a7 == SA);
    if (hit) begin
      ptr = r;
      foreach (data[i]) begin
        exp_wr.push_back({ptr, data[i]});
        ptr = ptr + 8'd1;
      end
      exp_stop.push_back(ptr);
      m_reg = ptr;
    end
    i2c_start();
    send_byte({a7, 1'b0}, hit, "ack_write_addr");
    check("busy_after_addr", bus.busy, int'(hit));
    send_byte(r, hit, "ack_reg");
    foreach (data[i]) send_byte(data[i], hit, "ack_wdata");
    i2c_stop();
    check("busy_after_stop", bus.busy, 0);
  endtask

  task automatic do_read(input logic [6:0] a7, input logic set_reg, input logic [7:0] r, input int n);
    logic hit;
    hit = (a7 == SA);
    i2c_start();
    if (set_reg) begin
      send_byte({a7, 1'b0}, hit, "ack_write_addr");
      send_byte(r, hit, "ack_reg");
      if (hit) begin
        m_reg = r;
        exp_stop.push_back(r);
      end
      i2c_start();
    end
    if (hit) exp_rd.push_back(m_reg);
    send_byte({a7, 1'b1}, hit, "ack_read_addr");
    check("busy_after_addr", bus.busy, int'(hit));
    for (int i = 0; i < n; i++) begin
      if (hit) begin
        if (i < n - 1) begin
          m_reg = m_reg + 8'd1;
          exp_rd.push_back(m_reg);
        end else begin
          exp_stop.push_back(m_reg);
        end
      end
      read_byte(i == n - 1);
    end
    check("busy_after_nack", bus.busy, 0);
    i2c_stop();
    check("busy_after_stop", bus.busy, 0);
  endtask

  // Both lines move in the same cycle: neither edge pair may count as START or STOP
  task automatic do_glitch();
    bus.i2c_scl = 1'b0;
    bus.i2c_sda = 1'b0;
    quarter();
    send_byte({SA, 1'b0}, 1'b0, "glitch_no_ack");
    bus.i2c_sda = 1'b0;
    quarter();
    bus.i2c_scl = 1'b1;
    bus.i2c_sda = 1'b1;
    quarter();
    quarter();
    check("glitch_busy", bus.busy, 0);
  endtask

  task automatic check_outputs_clear(input string tag);
    check({tag, "_ack"}, bus.i2c_ack, 0);
    check({tag, "_xfc_read"}, bus.i2c_xfc_read, 0);
    check({tag, "_xfc_write"}, bus.i2c_xfc_write, 0);
    check({tag, "_wdata"}, bus.i2c_wdata, 0);
    check({tag, "_reg_addr"}, bus.i2c_reg_addr, 0);
    check({tag, "_stop_out"}, bus.stop_out, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  // Reset lands after the fourth bit of a data byte; the rest of the byte must be ignored
  task automatic do_reset_mid();
    logic [7:0] r, d;
    r = 8'($urandom_range(1, 255));
    d = 8'($urandom);
    i2c_start();
    send_byte({SA, 1'b0}, 1'b1, "ack_write_addr");
    send_byte(r, 1'b1, "ack_reg");
    for (int i = 7; i >= 4; i--) clk_bit(d[i], 1'b0, "ack_low_on_data");
    #1 reset = 1'b1;
    #1 check_outputs_clear("midreset");
    repeat (3) @(posedge Clock);
    #2 reset = 1'b0;
    m_reg = 8'h00;
    for (int i = 3; i >= 0; i--) clk_bit(d[i], 1'b0, "postreset_data");
    clk_bit(1'b1, 1'b0, "postreset_no_ack");
    i2c_stop();
    check("postreset_busy", bus.busy, 0);
  endtask

  function automatic logic [6:0] miss_addr();
    logic [6:0] a;
    a = 7'($urandom_range(0, 127));
    if (a == SA) a = a ^ 7'h01;
    return a;
  endfunction

  initial begin
    logic [7:0] dq[$];
    logic [6:0] a7;
    logic [7:0] r;
    int         k, n;

    reset       = 1'b1;
    bus.i2c_scl = 1'b1;
    bus.i2c_sda = 1'b1;
    repeat (3) @(posedge Clock);
    #2 check_outputs_clear("reset");
    reset = 1'b0;
    quarter();
    quarter();

    dq = {8'h5A};
    do_write(SA, 8'h10, dq);
    do_read(SA, 1'b1, 8'h20, 2);
    dq = {};
    do_write(7'h58, 8'h33, dq);
    dq = {8'($urandom), 8'($urandom), 8'($urandom)};
    do_write(SA, 8'hFE, dq);
    do_reset_mid();
    do_glitch();
    do_read(SA, 1'b0, 8'h00, 2);

    for (int t = 0; t < 24; t++) begin
      k  = $urandom_range(0, 4);
      a7 = ($urandom_range(0, 4) == 0) ? miss_addr() : SA;
      r  = 8'($urandom);
      n  = $urandom_range(0, 3);
      case (k)
        0: begin
          dq = {};
          for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
          do_write(a7, r, dq);
        end
        1:       do_read(a7, 1'b1, r, n + 1);
        2:       do_read(a7, 1'b0, r, n + 1);
        3:       do_glitch();
        default: do_reset_mid();
      endcase
    end

    repeat (20) @(posedge Clock);
    #2;
    check("pending_write_strobes", exp_wr.size(), 0);
    check("pending_read_strobes", exp_rd.size(), 0);
    check("pending_stop_pulses", exp_stop.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
